utim64_main_counter: RTL and testbench
======================================

UTIM64_MAIN_COUNTER -- requirements
Module: utim64_main_counter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 iCLOCK  input  1  sole clock; all state changes on its rising edge.
REQ-003 inRESET  input  1  asynchronous, active-low reset.
REQ-004 iCONF_WRITE  input  1  one-cycle strobe; loads the enable and prescale configuration.
REQ-005 iCONF_ENA  input  1  counter run enable, sampled on iCONF_WRITE.
REQ-006 iCONF_PRESCALE  input  8  prescale value N, sampled on iCONF_WRITE; counter advances once per N+1 clocks.
REQ-007 iCOUNT_WRITE  input  1  one-cycle strobe; direct load of the main count.
REQ-008 inCOUNT_DQM  input  2  active-low byte-lane mask: bit0 = [31:0], bit1 = [63:32]; 0 = write that half.
REQ-009 iCOUNT_COUNTER  input  64  load data for iCOUNT_WRITE.
REQ-010 iSNAP_REQ  input  1  one-cycle snapshot request.
REQ-011 iOVF_ACK  input  1  clears the overflow pending flag.
REQ-012 oWORKING  output  1  registered enable state; feeds the comparator stage's iMTIMER_WORKING input.
REQ-013 oCOUNT  output  64  live main count register; feeds the comparator stage's iMTIMER_COUNT input.
REQ-014 oSNAP_COUNT  output  64  coherent 64-bit snapshot for 32-bit bus reads.
REQ-015 oSNAP_VALID  output  1  one-cycle pulse; oSNAP_COUNT is updated in the same cycle.
REQ-016 oOVF_IRQ  output  1  level; overflow pending.

Function
REQ-017 On iCONF_WRITE: enable <= iCONF_ENA, prescale <= iCONF_PRESCALE, prescaler counter <= 0; no tick in that cycle.
REQ-018 Prescaler: 8-bit counter; while enable=1 and no iCONF_WRITE/iCOUNT_WRITE, increments each clock; on reaching prescale it returns to 0 and generates a tick.
REQ-019 Prescale N=0 SHALL tick every enabled cycle; N=255 SHALL tick every 256th cycle.
REQ-020 Tick: count <= count + 1, modulo 2^64.
REQ-021 Wrap: tick with count = 64'hFFFF_FFFF_FFFF_FFFF SHALL give count = 0 and set the overflow pending flag.
REQ-022 iCOUNT_WRITE: each half with DQM bit = 0 loads from iCOUNT_COUNTER; each half with DQM bit = 1 holds; prescaler <= 0; no tick that cycle.
REQ-023 iCOUNT_WRITE with inCOUNT_DQM = 2'b11 SHALL leave count unchanged but still clear the prescaler and suppress the tick.
REQ-024 Simultaneous iCONF_WRITE and iCOUNT_WRITE: both SHALL take effect; no tick.
REQ-025 enable=0: prescaler and count hold; iCOUNT_WRITE still applies.
REQ-026 Snapshot: on iSNAP_REQ, oSNAP_COUNT <= the count value before that edge's update, and oSNAP_VALID = 1 for the following cycle only.
REQ-027 Back-to-back iSNAP_REQ SHALL snapshot every cycle, with oSNAP_VALID held high.
REQ-028 Overflow flag: set has priority over iOVF_ACK in the same cycle; otherwise iOVF_ACK clears it; oOVF_IRQ = flag.
REQ-029 oWORKING = enable register; oCOUNT = count register; no combinational path from inputs to outputs.

Reset
REQ-030 inRESET low SHALL immediately clear enable, prescale, prescaler, count, oSNAP_COUNT, oSNAP_VALID and the overflow flag to 0, independent of iCLOCK.
REQ-031 Reset asserted mid-count or mid-prescale SHALL abandon the operation; after release, the block idles until iCONF_WRITE.

Verification
REQ-032 Prescale: CONF_WRITE ENA=1, N=3 from reset -> oCOUNT = 1 after 4 clocks and = 5 after 20 clocks; oWORKING = 1 the cycle after the write.
REQ-033 Masked load: count = 0, COUNT_WRITE, DQM = 2'b10, data 64'h1111_2222_3333_4444 -> oCOUNT = 64'h0000_0000_3333_4444; then DQM = 2'b01, data 64'hAAAA_BBBB_0000_0000 -> 64'hAAAA_BBBB_3333_4444.
REQ-034 Wrap: load 64'hFFFF_FFFF_FFFF_FFFE, N=0, ENA=1 -> oCOUNT = 0 two ticks later, oOVF_IRQ = 1; iOVF_ACK -> 0 next cycle; ACK coincident with a new wrap -> stays 1.
REQ-035 Snapshot: while running at N=0, iSNAP_REQ when oCOUNT = 64'h0000_0001_FFFF_FFFF -> next cycle oSNAP_VALID = 1 and oSNAP_COUNT = 64'h0000_0001_FFFF_FFFF while oCOUNT = 64'h0000_0002_0000_0000.
REQ-036 Stop/priority: running, CONF_WRITE ENA=0 -> count frozen; COUNT_WRITE while stopped still loads; COUNT_WRITE coincident with a tick -> loaded value, no increment.
REQ-037 Async reset: assert inRESET between clock edges at count = 64'h55 -> all outputs 0 before the next edge; count stays 0 after release until configured.

Source files
------------

// File: rtl/utim64_main_counter.sv
// ----------------------------------------------------------------------------
// utim64_main_counter
//
// Free-running 64-bit timer main counter with an 8-bit prescaler, direct
// masked load, coherent snapshot for 32-bit bus readers and a sticky
// overflow interrupt.
//
// Ports
//   iCLOCK          in   1   sole clock, rising edge
//   inRESET         in   1   asynchronous active-low reset
//   iCONF_WRITE     in   1   strobe: load enable/prescale, clear prescaler
//   iCONF_ENA       in   1   run enable sampled on iCONF_WRITE
//   iCONF_PRESCALE  in   8   prescale N; count advances once per N+1 clocks
//   iCOUNT_WRITE    in   1   strobe: direct load of the main count
//   inCOUNT_DQM     in   2   active-low half mask (bit0 = [31:0], bit1 = [63:32])
//   iCOUNT_COUNTER  in   64  load data for iCOUNT_WRITE
//   iSNAP_REQ       in   1   snapshot request
//   iOVF_ACK        in   1   clears the overflow pending flag
//   oWORKING        out  1   registered enable state
//   oCOUNT          out  64  live main count
//   oSNAP_COUNT     out  64  captured count (value before the request edge)
//   oSNAP_VALID     out  1   high the cycle after each snapshot request
//   oOVF_IRQ        out  1   overflow pending level
// ----------------------------------------------------------------------------
module utim64_main_counter (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iCONF_WRITE,
  input  logic        iCONF_ENA,
  input  logic [7:0]  iCONF_PRESCALE,
  input  logic        iCOUNT_WRITE,
  input  logic [1:0]  inCOUNT_DQM,
  input  logic [63:0] iCOUNT_COUNTER,
  input  logic        iSNAP_REQ,
  input  logic        iOVF_ACK,
  output logic        oWORKING,
  output logic [63:0] oCOUNT,
  output logic [63:0] oSNAP_COUNT,
  output logic        oSNAP_VALID,
  output logic        oOVF_IRQ
);

  logic        enable;
  logic [7:0]  prescale;
  logic [7:0]  prescaler;
  logic [63:0] count;
  logic [63:0] snapCount;
  logic        snapValid;
  logic        ovfFlag;

  logic        loadStrobe;
  logic        prescaleHit;
  logic        tick;
  logic        wrap;

  // Any configuration or count write restarts the prescale period and
  // swallows the tick that would otherwise land on that edge.
  assign loadStrobe  = iCONF_WRITE | iCOUNT_WRITE;
  assign prescaleHit = (prescaler == prescale);
  assign tick        = enable & ~loadStrobe & prescaleHit;
  assign wrap        = tick & (count == {64{1'b1}});

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      enable   <= 1'b0;
      prescale <= 8'd0;
    end else if (iCONF_WRITE) begin
      enable   <= iCONF_ENA;
      prescale <= iCONF_PRESCALE;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      prescaler <= 8'd0;
    end else if (loadStrobe) begin
      prescaler <= 8'd0;
    end else if (enable) begin
      if (prescaleHit) begin
        prescaler <= 8'd0;
      end else begin
        prescaler <= prescaler + 8'd1;
      end
    end
  end

  // A count write always beats a tick; a fully masked write (DQM = 2'b11)
  // leaves the count alone but still suppresses the tick via loadStrobe.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      count <= 64'd0;
    end else if (iCOUNT_WRITE) begin
      if (!inCOUNT_DQM[0]) begin
        count[31:0] <= iCOUNT_COUNTER[31:0];
      end
      if (!inCOUNT_DQM[1]) begin
        count[63:32] <= iCOUNT_COUNTER[63:32];
      end
    end else if (tick) begin
      count <= count + 64'd1;
    end
  end

  // Snapshot captures the pre-edge count so both 32-bit halves read back
  // from one coherent instant.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      snapCount <= 64'd0;
      snapValid <= 1'b0;
    end else begin
      snapValid <= iSNAP_REQ;
      if (iSNAP_REQ) begin
        snapCount <= count;
      end
    end
  end

  // A new wrap wins over an acknowledge in the same cycle so no event is lost.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ovfFlag <= 1'b0;
    end else if (wrap) begin
      ovfFlag <= 1'b1;
    end else if (iOVF_ACK) begin
      ovfFlag <= 1'b0;
    end
  end

  assign oWORKING    = enable;
  assign oCOUNT      = count;
  assign oSNAP_COUNT = snapCount;
  assign oSNAP_VALID = snapValid;
  assign oOVF_IRQ    = ovfFlag;

endmodule

// File: tb/tb_utim64_main_counter.sv
module tb_utim64_main_counter;

  logic        iCLOCK;
  logic        inRESET;
  logic        iCONF_WRITE;
  logic        iCONF_ENA;
  logic [7:0]  iCONF_PRESCALE;
  logic        iCOUNT_WRITE;
  logic [1:0]  inCOUNT_DQM;
  logic [63:0] iCOUNT_COUNTER;
  logic        iSNAP_REQ;
  logic        iOVF_ACK;
  logic        oWORKING;
  logic [63:0] oCOUNT;
  logic [63:0] oSNAP_COUNT;
  logic        oSNAP_VALID;
  logic        oOVF_IRQ;

  int compared   = 0;
  int mismatched = 0;

  utim64_main_counter dut (
    .iCLOCK         (iCLOCK),
    .inRESET        (inRESET),
    .iCONF_WRITE    (iCONF_WRITE),
    .iCONF_ENA      (iCONF_ENA),
    .iCONF_PRESCALE (iCONF_PRESCALE),
    .iCOUNT_WRITE   (iCOUNT_WRITE),
    .inCOUNT_DQM    (inCOUNT_DQM),
    .iCOUNT_COUNTER (iCOUNT_COUNTER),
    .iSNAP_REQ      (iSNAP_REQ),
    .iOVF_ACK       (iOVF_ACK),
    .oWORKING       (oWORKING),
    .oCOUNT         (oCOUNT),
    .oSNAP_COUNT    (oSNAP_COUNT),
    .oSNAP_VALID    (oSNAP_VALID),
    .oOVF_IRQ       (oOVF_IRQ)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic test_reset();
    inRESET        = 1'b0;
    iCONF_WRITE    = 1'b0;
    iCONF_ENA      = 1'b0;
    iCONF_PRESCALE = 8'd0;
    iCOUNT_WRITE   = 1'b0;
    inCOUNT_DQM    = 2'b11;
    iCOUNT_COUNTER = 64'd0;
    iSNAP_REQ      = 1'b0;
    iOVF_ACK       = 1'b0;
    repeat (3) step();
    inRESET = 1'b1;
    repeat (3) step();
    compared++;
    if ({oWORKING, oSNAP_VALID, oOVF_IRQ} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_flags: got %b want 000", {oWORKING, oSNAP_VALID, oOVF_IRQ});
    end
    compared++;
    if (oCOUNT !== 64'd0 || oSNAP_COUNT !== 64'd0) begin
      mismatched++;
      $display("FAIL reset_counts: count %h snap %h want 0", oCOUNT, oSNAP_COUNT);
    end
  endtask

  task automatic test_prescale();
    iCONF_WRITE = 1'b1; iCONF_ENA = 1'b1; iCONF_PRESCALE = 8'd3;
    step();
    iCONF_WRITE = 1'b0;
    compared++;
    if (oWORKING !== 1'b1 || oCOUNT !== 64'd0) begin
      mismatched++;
      $display("FAIL prescale_conf: working %b count %0d want 1 0", oWORKING, oCOUNT);
    end
    repeat (3) step();
    compared++;
    if (oCOUNT !== 64'd0) begin
      mismatched++;
      $display("FAIL prescale_3clk: count %0d want 0", oCOUNT);
    end
    step();
    compared++;
    if (oCOUNT !== 64'd1) begin
      mismatched++;
      $display("FAIL prescale_4clk: count %0d want 1", oCOUNT);
    end
    repeat (16) step();
    compared++;
    if (oCOUNT !== 64'd5) begin
      mismatched++;
      $display("FAIL prescale_20clk: count %0d want 5", oCOUNT);
    end
  endtask

  task automatic test_masked_load();
    iCONF_WRITE = 1'b1; iCONF_ENA = 1'b0; iCONF_PRESCALE = 8'd0;
    iCOUNT_WRITE = 1'b1; inCOUNT_DQM = 2'b00; iCOUNT_COUNTER = 64'd0;
    step();
    iCONF_WRITE = 1'b0;
    compared++;
    if (oCOUNT !== 64'd0 || oWORKING !== 1'b0) begin
      mismatched++;
      $display("FAIL load_zero: count %h working %b want 0 0", oCOUNT, oWORKING);
    end
    inCOUNT_DQM = 2'b10; iCOUNT_COUNTER = 64'h1111_2222_3333_4444;
    step();
    compared++;
    if (oCOUNT !== 64'h0000_0000_3333_4444) begin
      mismatched++;
      $display("FAIL load_low: count %h want 0000000033334444", oCOUNT);
    end
    inCOUNT_DQM = 2'b01; iCOUNT_COUNTER = 64'hAAAA_BBBB_0000_0000;
    step();
    compared++;
    if (oCOUNT !== 64'hAAAA_BBBB_3333_4444) begin
      mismatched++;
      $display("FAIL load_high: count %h want aaaabbbb33334444", oCOUNT);
    end
    inCOUNT_DQM = 2'b11; iCOUNT_COUNTER = 64'h0123_4567_89AB_CDEF;
    step();
    iCOUNT_WRITE = 1'b0;
    compared++;
    if (oCOUNT !== 64'hAAAA_BBBB_3333_4444) begin
      mismatched++;
      $display("FAIL load_masked: count %h want aaaabbbb33334444", oCOUNT);
    end
  endtask

  task automatic test_wrap();
    // Concurrent conf + count write: both apply, no tick.
    iCONF_WRITE = 1'b1; iCONF_ENA = 1'b1; iCONF_PRESCALE = 8'd0;
    iCOUNT_WRITE = 1'b1; inCOUNT_DQM = 2'b00; iCOUNT_COUNTER = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    iCONF_WRITE = 1'b0; iCOUNT_WRITE = 1'b0;
    compared++;
    if (oCOUNT !== 64'hFFFF_FFFF_FFFF_FFFE || oWORKING !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_load: count %h working %b want fffffffffffffffe 1", oCOUNT, oWORKING);
    end
    step();
    compared++;
    if (oCOUNT !== 64'hFFFF_FFFF_FFFF_FFFF || oOVF_IRQ !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_pre: count %h irq %b want ffffffffffffffff 0", oCOUNT, oOVF_IRQ);
    end
    step();
    compared++;
    if (oCOUNT !== 64'd0 || oOVF_IRQ !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_zero: count %h irq %b want 0 1", oCOUNT, oOVF_IRQ);
    end
    iOVF_ACK = 1'b1;
    step();
    iOVF_ACK = 1'b0;
    compared++;
    if (oOVF_IRQ !== 1'b0 || oCOUNT !== 64'd1) begin
      mismatched++;
      $display("FAIL wrap_ack: irq %b count %0d want 0 1", oOVF_IRQ, oCOUNT);
    end
    iCOUNT_WRITE = 1'b1; iCOUNT_COUNTER = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    iCOUNT_WRITE = 1'b0;
    iOVF_ACK = 1'b1;
    step();
    iOVF_ACK = 1'b0;
    compared++;
    if (oOVF_IRQ !== 1'b1 || oCOUNT !== 64'd0) begin
      mismatched++;
      $display("FAIL wrap_ack_collide: irq %b count %h want 1 0", oOVF_IRQ, oCOUNT);
    end
    step();
    compared++;
    if (oOVF_IRQ !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_sticky: irq %b want 1", oOVF_IRQ);
    end
    iOVF_ACK = 1'b1;
    step();
    iOVF_ACK = 1'b0;
  endtask

  task automatic test_snapshot();
    // Still running at N=0.
    iCOUNT_WRITE = 1'b1; inCOUNT_DQM = 2'b00; iCOUNT_COUNTER = 64'h0000_0001_FFFF_FFFE;
    step();
    iCOUNT_WRITE = 1'b0;
    step();
    compared++;
    if (oCOUNT !== 64'h0000_0001_FFFF_FFFF || oSNAP_VALID !== 1'b0) begin
      mismatched++;
      $display("FAIL snap_setup: count %h valid %b want 00000001ffffffff 0", oCOUNT, oSNAP_VALID);
    end
    iSNAP_REQ = 1'b1;
    step();
    compared++;
    if (oSNAP_VALID !== 1'b1 || oSNAP_COUNT !== 64'h0000_0001_FFFF_FFFF ||
        oCOUNT !== 64'h0000_0002_0000_0000) begin
      mismatched++;
      $display("FAIL snap_first: valid %b snap %h count %h want 1 00000001ffffffff 0000000200000000",
               oSNAP_VALID, oSNAP_COUNT, oCOUNT);
    end
    step();
    iSNAP_REQ = 1'b0;
    compared++;
    if (oSNAP_VALID !== 1'b1 || oSNAP_COUNT !== 64'h0000_0002_0000_0000) begin
      mismatched++;
      $display("FAIL snap_back2back: valid %b snap %h want 1 0000000200000000", oSNAP_VALID, oSNAP_COUNT);
    end
    step();
    compared++;
    if (oSNAP_VALID !== 1'b0 || oSNAP_COUNT !== 64'h0000_0002_0000_0000) begin
      mismatched++;
      $display("FAIL snap_hold: valid %b snap %h want 0 0000000200000000", oSNAP_VALID, oSNAP_COUNT);
    end
  endtask

  task automatic test_stop_priority();
    iCOUNT_WRITE = 1'b1; inCOUNT_DQM = 2'b00; iCOUNT_COUNTER = 64'h100;
    step();
    iCOUNT_WRITE = 1'b0;
    step();
    iCONF_WRITE = 1'b1; iCONF_ENA = 1'b0; iCONF_PRESCALE = 8'd0;
    step();
    iCONF_WRITE = 1'b0;
    repeat (5) step();
    compared++;
    if (oCOUNT !== 64'h101 || oWORKING !== 1'b0) begin
      mismatched++;
      $display("FAIL stop_frozen: count %h working %b want 101 0", oCOUNT, oWORKING);
    end
    iCOUNT_WRITE = 1'b1; iCOUNT_COUNTER = 64'h1234;
    step();
    iCOUNT_WRITE = 1'b0;
    step();
    compared++;
    if (oCOUNT !== 64'h1234) begin
      mismatched++;
      $display("FAIL stop_load: count %h want 1234", oCOUNT);
    end
    iCONF_WRITE = 1'b1; iCONF_ENA = 1'b1;
    step();
    iCONF_WRITE = 1'b0;
    iCOUNT_WRITE = 1'b1; iCOUNT_COUNTER = 64'hABCD;
    step();
    iCOUNT_WRITE = 1'b0;
    compared++;
    if (oCOUNT !== 64'hABCD) begin
      mismatched++;
      $display("FAIL load_over_tick: count %h want abcd", oCOUNT);
    end
    step();
    compared++;
    if (oCOUNT !== 64'hABCE) begin
      mismatched++;
      $display("FAIL resume_tick: count %h want abce", oCOUNT);
    end
  endtask

  task automatic test_prescale_max();
    iCONF_WRITE = 1'b1; iCONF_ENA = 1'b1; iCONF_PRESCALE = 8'd255;
    iCOUNT_WRITE = 1'b1; inCOUNT_DQM = 2'b00; iCOUNT_COUNTER = 64'd0;
    step();
    iCONF_WRITE = 1'b0; iCOUNT_WRITE = 1'b0;
    repeat (255) step();
    compared++;
    if (oCOUNT !== 64'd0) begin
      mismatched++;
      $display("FAIL prescale255_early: count %0d want 0", oCOUNT);
    end
    step();
    compared++;
    if (oCOUNT !== 64'd1) begin
      mismatched++;
      $display("FAIL prescale255_tick: count %0d want 1", oCOUNT);
    end
  endtask

  task automatic test_async_reset();
    iCONF_WRITE = 1'b1; iCONF_ENA = 1'b1; iCONF_PRESCALE = 8'd0;
    iCOUNT_WRITE = 1'b1; inCOUNT_DQM = 2'b00; iCOUNT_COUNTER = 64'h53;
    step();
    iCONF_WRITE = 1'b0; iCOUNT_WRITE = 1'b0;
    step();
    iSNAP_REQ = 1'b1;
    step();
    iSNAP_REQ = 1'b0;
    compared++;
    if (oCOUNT !== 64'h55 || oSNAP_VALID !== 1'b1 || oSNAP_COUNT !== 64'h54) begin
      mismatched++;
      $display("FAIL areset_setup: count %h valid %b snap %h want 55 1 54", oCOUNT, oSNAP_VALID, oSNAP_COUNT);
    end
    #2;
    inRESET = 1'b0;
    #1;
    compared++;
    if (oCOUNT !== 64'd0 || oSNAP_COUNT !== 64'd0 ||
        {oWORKING, oSNAP_VALID, oOVF_IRQ} !== 3'b000) begin
      mismatched++;
      $display("FAIL areset_immediate: count %h snap %h flags %b want 0 0 000",
               oCOUNT, oSNAP_COUNT, {oWORKING, oSNAP_VALID, oOVF_IRQ});
    end
    step();
    step();
    #3;
    inRESET = 1'b1;
    repeat (4) step();
    compared++;
    if (oCOUNT !== 64'd0 || oWORKING !== 1'b0) begin
      mismatched++;
      $display("FAIL areset_idle: count %h working %b want 0 0", oCOUNT, oWORKING);
    end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_masked_load();
    test_wrap();
    test_snapshot();
    test_stop_priority();
    test_prescale_max();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
